// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction-cache miss controller.
// Line address = {tag, index}; word select picks one 16-bit word of a 64-bit line.
package icache_pkg;

    localparam int LINE_W     = 64;
    localparam int TAG_W      = 11;
    localparam int INDEX_W    = 3;
    localparam int WORD_SEL_W = 2;
    localparam int WORD_W     = LINE_W / (1 << WORD_SEL_W);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COMPARE  = 3'd1,
        REQ      = 3'd2,
        MEM_WAIT = 3'd3,
        FILL     = 3'd4,
        RETRY    = 3'd5
    } state_t;

endpackage

// File: rtl/icache_word_mux.sv
// Selects one 16-bit instruction word out of a 64-bit cache line.
module icache_word_mux
    import icache_pkg::*;
(
    input  logic [LINE_W-1:0]     i_line,
    input  logic [WORD_SEL_W-1:0] i_sel,
    output logic [WORD_W-1:0]     o_word
);

    assign o_word = i_line[WORD_W*i_sel +: WORD_W];

endmodule

// File: rtl/icache_ctrl.sv
// Miss controller for the direct-mapped instruction cache: serves hits with zero
// added latency, and on a miss fetches the line from the shared memory port, fills it and retries.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int MEM_LAT = 4,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_re,
    output logic [WORD_W-1:0] instr,
    output logic              stall,
    output logic [ADDR_W-3:0] c_addr,
    output logic              c_re,
    output logic              c_we,
    output logic [LINE_W-1:0] c_wr_data,
    output logic              c_wdirty,
    input  logic [LINE_W-1:0] c_rd_data,
    input  logic              c_hit,
    output logic              m_req,
    input  logic              m_gnt,
    output logic [ADDR_W-3:0] m_addr,
    output logic              m_re,
    input  logic [LINE_W-1:0] m_rd_data,
    input  logic              m_rdy
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_lat_cnt;
    logic [ADDR_W-3:0] r_miss_addr;
    logic [LINE_W-1:0] r_line_buf;
    logic [WORD_W-1:0] w_word;
    logic              w_lookup;
    logic              w_mem_done;

    // The lookup path is combinational from inputs, so it is gated by rst_n to keep
    // every output at its reset value while reset is held.
    assign w_lookup   = rst_n && if_re && (r_state == IDLE || r_state == COMPARE);
    assign w_mem_done = (r_state == MEM_WAIT) &&
                        (m_rdy || (r_lat_cnt == CNT_W'(MEM_LAT - 1)));

    assign c_wr_data  = r_line_buf;
    assign c_wdirty   = 1'b0;

    icache_word_mux u_word_mux (
        .i_line (c_rd_data),
        .i_sel  (if_addr[WORD_SEL_W-1:0]),
        .o_word (w_word)
    );

    // NOTE: state lives in always_ff with non-blocking assignments and an async
    // active-low reset; every register, including the line buffer, gets a reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_lat_cnt   <= '0;
            r_miss_addr <= '0;
            r_line_buf  <= '0;
        end else begin
            r_state <= w_next;
            if (w_lookup && !c_hit) begin
                r_miss_addr <= if_addr[ADDR_W-1:2];
            end
            if (r_state == REQ) begin
                r_lat_cnt <= '0;
            end else if (r_state == MEM_WAIT) begin
                r_lat_cnt <= r_lat_cnt + 1'b1;
            end
            if (w_mem_done) begin
                r_line_buf <= m_rd_data;
            end
        end
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_next = r_state;
        stall  = 1'b0;
        instr  = '0;
        c_re   = 1'b0;
        c_we   = 1'b0;
        c_addr = '0;
        m_req  = 1'b0;
        m_re   = 1'b0;
        m_addr = '0;
        case (r_state)
            IDLE, COMPARE: begin
                if (w_lookup) begin
                    c_re   = 1'b1;
                    c_addr = if_addr[ADDR_W-1:2];
                    if (c_hit) begin
                        instr  = w_word;
                        w_next = COMPARE;
                    end else begin
                        stall  = 1'b1;
                        w_next = REQ;
                    end
                end else begin
                    w_next = IDLE;
                end
            end
            REQ: begin
                stall  = 1'b1;
                m_req  = 1'b1;
                m_addr = r_miss_addr;
                if (m_gnt) begin
                    w_next = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                stall  = 1'b1;
                m_req  = 1'b1;
                m_re   = 1'b1;
                m_addr = r_miss_addr;
                if (w_mem_done) begin
                    w_next = FILL;
                end
            end
            FILL: begin
                stall  = 1'b1;
                c_we   = 1'b1;
                c_addr = r_miss_addr;
                w_next = RETRY;
            end
            RETRY: begin
                stall  = 1'b1;
                c_re   = 1'b1;
                c_addr = r_miss_addr;
                // A fetch abandoned mid-miss still gets its line filled, then the block idles.
                w_next = if_re ? COMPARE : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: behavioural cache array and memory port around the DUT,
// a directed vector table, multi-cycle corner sequences and a randomized phase.
module tb_icache_ctrl;

    localparam int MEM_LAT = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] if_addr;
    logic        if_re;
    logic [15:0] instr;
    logic        stall;
    logic [13:0] c_addr;
    logic        c_re;
    logic        c_we;
    logic [63:0] c_wr_data;
    logic        c_wdirty;
    logic [63:0] c_rd_data;
    logic        c_hit;
    logic        m_req;
    logic        m_gnt;
    logic [13:0] m_addr;
    logic        m_re;
    logic [63:0] m_rd_data;
    logic        m_rdy;

    int n_cmp = 0;
    int n_err = 0;

    icache_ctrl #(.MEM_LAT(MEM_LAT), .ADDR_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_addr   (if_addr),
        .if_re     (if_re),
        .instr     (instr),
        .stall     (stall),
        .c_addr    (c_addr),
        .c_re      (c_re),
        .c_we      (c_we),
        .c_wr_data (c_wr_data),
        .c_wdirty  (c_wdirty),
        .c_rd_data (c_rd_data),
        .c_hit     (c_hit),
        .m_req     (m_req),
        .m_gnt     (m_gnt),
        .m_addr    (m_addr),
        .m_re      (m_re),
        .m_rd_data (m_rd_data),
        .m_rdy     (m_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Main memory contents: each 16-bit word is a fixed scramble of its word address.
    function automatic logic [15:0] word_of(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A3C;
    endfunction

    function automatic logic [63:0] mem_line(input logic [13:0] la);
        logic [63:0] l;
        for (int w = 0; w < 4; w++) begin
            l[w*16 +: 16] = word_of({la, 2'(w)});
        end
        return l;
    endfunction

    // Cache array environment: tag/valid/data per index, valid bits cleared by reset.
    logic        arr_valid [8];
    logic [10:0] arr_tag   [8];
    logic [63:0] arr_data  [8];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) arr_valid[i] <= 1'b0;
        end else if (c_we) begin
            arr_valid[c_addr[2:0]] <= 1'b1;
            arr_tag[c_addr[2:0]]   <= c_addr[13:3];
            arr_data[c_addr[2:0]]  <= c_wr_data;
        end
    end

    assign c_hit     = c_re && arr_valid[c_addr[2:0]] && (arr_tag[c_addr[2:0]] == c_addr[13:3]);
    assign c_rd_data = arr_data[c_addr[2:0]];

    // Memory port environment: grant after gnt_delay request cycles, data on the
    // rdy_at-th read cycle (rdy_at beyond MEM_LAT means m_rdy never comes).
    int gnt_delay = 0;
    int rdy_at    = MEM_LAT;
    int gnt_cnt;
    int re_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt <= 0;
            re_cnt  <= 0;
        end else begin
            gnt_cnt <= m_req ? gnt_cnt + 1 : 0;
            re_cnt  <= m_re  ? re_cnt + 1  : 0;
        end
    end

    assign m_gnt     = m_req && (gnt_cnt >= gnt_delay);
    assign m_rdy     = m_re && (re_cnt == rdy_at - 1);
    assign m_rd_data = mem_line(m_addr);

    // Protocol monitor, sampled mid-cycle.
    int          we_cnt   = 0;
    int          mreq_cnt = 0;
    logic [13:0] last_m_addr;
    logic        prev_rdy = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (c_we) begin
                we_cnt++;
                check("fill_data", c_wr_data, mem_line(c_addr));
                check("fill_excl_re", c_re, 1'b0);
                check("fill_dirty", c_wdirty, 1'b0);
            end
            if (m_re) check("gnt_held", m_gnt, 1'b1);
            if (m_req) begin
                mreq_cnt++;
                last_m_addr = m_addr;
                if (!m_gnt) check("req_no_re", m_re, 1'b0);
            end
            if (prev_rdy) check("req_release", m_req, 1'b0);
            prev_rdy = m_rdy;
        end else begin
            prev_rdy = 1'b0;
        end
    end

    // Reference model: which line address each direct-mapped index holds.
    logic        ref_valid [8];
    logic [13:0] ref_line  [8];

    function automatic bit model_hit(input logic [15:0] a);
        return ref_valid[a[4:2]] && (ref_line[a[4:2]] == a[15:2]);
    endfunction

    function automatic void model_fill(input logic [15:0] a);
        ref_valid[a[4:2]] = 1'b1;
        ref_line[a[4:2]]  = a[15:2];
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
    endfunction

    function automatic int model_stall(input logic [15:0] a, input int gd, input int ra);
        if (model_hit(a)) return 0;
        return 4 + gd + ((ra < MEM_LAT) ? ra : MEM_LAT);
    endfunction

    // Issues a fetch and holds it until stall drops; checks stall length, word, side effects.
    task automatic fetch(input logic [15:0] a, input int gd, input int ra, input int exp_stall);
        int  n;
        int  we0;
        int  mr0;
        bit  miss;
        miss      = !model_hit(a);
        gnt_delay = gd;
        rdy_at    = ra;
        we0       = we_cnt;
        mr0       = mreq_cnt;
        if_addr   = a;
        if_re     = 1'b1;
        #1;
        n = 0;
        while (stall && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check($sformatf("stall_cycles@%h", a), 64'(n), 64'(exp_stall));
        check($sformatf("instr@%h", a), instr, word_of(a));
        check($sformatf("fills@%h", a), 64'(we_cnt - we0), miss ? 64'd1 : 64'd0);
        if (miss) check($sformatf("m_addr@%h", a), last_m_addr, a[15:2]);
        else      check($sformatf("no_req@%h", a), 64'(mreq_cnt - mr0), 64'd0);
        model_fill(a);
        @(negedge clk); #1;
    endtask

    task automatic wait_mem_wait(input string name);
        int k = 0;
        while (!m_re && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        check(name, m_re, 1'b1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_stall"},  stall,     1'b0);
        check({pfx, "_c_re"},   c_re,      1'b0);
        check({pfx, "_c_we"},   c_we,      1'b0);
        check({pfx, "_m_req"},  m_req,     1'b0);
        check({pfx, "_m_re"},   m_re,      1'b0);
        check({pfx, "_instr"},  instr,     16'h0000);
        check({pfx, "_c_addr"}, c_addr,    14'h0000);
        check({pfx, "_m_addr"}, m_addr,    14'h0000);
        check({pfx, "_wdirty"}, c_wdirty,  1'b0);
        check({pfx, "_wrdata"}, c_wr_data, 64'h0);
    endtask

    typedef struct {
        logic [15:0] addr;
        int          gd;
        int          ra;
        int          exp_stall;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{16'h0008, 0, 4, 8};   // cold miss, minimum penalty
        vecs[1]  = '{16'h0009, 0, 4, 0};   // words 1..3 of the same line
        vecs[2]  = '{16'h000A, 0, 4, 0};
        vecs[3]  = '{16'h000B, 0, 4, 0};
        vecs[4]  = '{16'h0028, 0, 4, 8};   // same index, different tag
        vecs[5]  = '{16'h0008, 5, 4, 13};  // evicted line, grant withheld 5 cycles
        vecs[6]  = '{16'h000B, 0, 4, 0};
        vecs[7]  = '{16'h0010, 0, 2, 6};   // early m_rdy ends the wait
        vecs[8]  = '{16'h0013, 0, 4, 0};
        vecs[9]  = '{16'h0031, 0, 9, 8};   // m_rdy never comes: timeout guard
        vecs[10] = '{16'h0030, 0, 4, 0};
        vecs[11] = '{16'h0029, 0, 4, 8};
        vecs[12] = '{16'h000A, 3, 1, 8};

        rst_n   = 1'b0;
        if_re   = 1'b1;
        if_addr = 16'h0008;
        model_clear();
        #3;
        check_reset_outputs("reset");
        @(negedge clk); @(negedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            fetch(vecs[i].addr, vecs[i].gd, vecs[i].ra, vecs[i].exp_stall);
        end

        // Reset asserted in the middle of MEM_WAIT aborts the miss without a fill.
        begin
            int we0;
            gnt_delay = 0;
            rdy_at    = MEM_LAT;
            if_addr   = 16'h0100;
            if_re     = 1'b1;
            wait_mem_wait("abort_reach_mem_wait");
            @(negedge clk);
            we0 = we_cnt;
            #2;
            rst_n = 1'b0;
            #1;
            check_reset_outputs("abort");
            model_clear();
            @(negedge clk); @(negedge clk); #1;
            rst_n = 1'b1;
            check("abort_no_fill", 64'(we_cnt - we0), 64'd0);
            fetch(16'h0100, 0, 4, 8);
        end

        // Fetch abandoned during MEM_WAIT: the line is still filled and the block idles.
        begin
            int we0;
            int k;
            gnt_delay = 0;
            rdy_at    = MEM_LAT;
            we0       = we_cnt;
            if_addr   = 16'h0200;
            if_re     = 1'b1;
            wait_mem_wait("drop_reach_mem_wait");
            if_re = 1'b0;
            k = 0;
            while (we_cnt == we0 && k < 20) begin
                @(negedge clk); #1;
                k++;
            end
            @(negedge clk); #1;
            @(negedge clk); #1;
            check("drop_fills", 64'(we_cnt - we0), 64'd1);
            check("drop_idle_stall", stall, 1'b0);
            check("drop_idle_c_re", c_re, 1'b0);
            check("drop_idle_m_req", m_req, 1'b0);
            model_fill(16'h0200);
            fetch(16'h0200, 0, 4, 0);
        end

        // Randomized fetch stream over a small address range for frequent conflicts.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            int gd;
            int ra;
            a  = 16'($urandom_range(0, 127));
            gd = int'($urandom_range(0, 3));
            ra = int'($urandom_range(1, 5));
            fetch(a, gd, ra, model_stall(a, gd, ra));
        end

        if_re = 1'b0;
        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
Miss controller for the direct-mapped 8-line, 64-bit-line instruction cache. Serves instruction fetches from the cache and stalls the fetch stage on a miss. On a miss it requests the shared main-memory port, waits out the memory latency, fills the line, then retries. It sits between the IF stage, the instruction cache array and the memory arbiter, which is shared with the data side.

Parameters:
MEM_LAT, 4, main-memory read latency in clk cycles, counted from the cycle m_re is first asserted.
ADDR_W, 16, fetch address width in 16-bit words.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
if_addr  in  16  word address of the instruction to fetch (PC)
if_re  in  1  fetch request, held high until stall deasserts
instr  out  16  fetched instruction word
stall  out  1  fetch not satisfied this cycle; IF holds PC
c_addr  out  14  cache line address, equal to if_addr[15:2]
c_re  out  1  cache read enable
c_we  out  1  cache line write enable
c_wr_data  out  64  line to write into the cache
c_wdirty  out  1  dirty bit to write; always 0
c_rd_data  in  64  line read from the cache
c_hit  in  1  tag match and valid, same cycle as c_re
m_req  out  1  request for the shared memory port
m_gnt  in  1  arbiter grant, level, valid while m_req is high
m_addr  out  14  memory line address
m_re  out  1  memory read strobe
m_rd_data  in  64  memory line data, valid on the cycle m_rdy is high
m_rdy  in  1  memory data valid, one-cycle pulse

Behaviour:
- Reset (async, rst_n low): state=IDLE, lat_cnt=0, line_buf=0.
- Reset values of outputs: stall=0, c_re=0, c_we=0, m_req=0, m_re=0, instr=16'h0000, c_wdirty=0, c_addr=0, m_addr=0.
- Reset mid-miss aborts the sequence. The cache array clears its own valid bits, so no partial fill may be written.
- States: IDLE, COMPARE, REQ, MEM_WAIT, FILL, RETRY.
- IDLE: if_re=0 -> stall=0, c_re=0. if_re=1 -> go to COMPARE in the same cycle; the decode is combinational from IDLE/COMPARE.
- COMPARE (also the steady-state hit path):
  - c_re=1, c_addr=if_addr[15:2].
  - c_hit=1 -> stall=0; instr = 16-bit word if_addr[1:0] of c_rd_data (word 0 = bits[15:0], word 3 = bits[63:48]). Zero added latency.
  - c_hit=0 -> stall=1; latch miss_addr=if_addr[15:2]; go to REQ.
- REQ: stall=1, m_req=1, m_addr=miss_addr. Stay while m_gnt=0. m_gnt=1 -> go to MEM_WAIT and load lat_cnt=0.
- MEM_WAIT:
  - stall=1, m_req=1, m_re=1, m_addr=miss_addr; lat_cnt increments each cycle.
  - Leave on m_rdy=1, or when lat_cnt reaches MEM_LAT-1 (timeout guard; m_rdy is authoritative).
  - On leaving, capture m_rd_data into line_buf and go to FILL.
  - m_gnt dropping while in MEM_WAIT is illegal; the bench asserts on it.
- FILL: stall=1, m_req=0, c_we=1 for exactly one cycle, c_addr=miss_addr, c_wr_data=line_buf, c_wdirty=0. Go to RETRY.
- RETRY: stall=1, c_re=1, c_addr=miss_addr; re-lookup. Go to COMPARE next cycle.
- Minimum miss penalty with an immediate grant: 1 (COMPARE) + 1 (REQ) + MEM_LAT + 1 (FILL) + 1 (RETRY) = 8 stalled cycles. The hit is delivered on the 9th cycle.
- if_addr change during a miss is ignored; miss_addr governs the fill. The retry compares against the current if_addr, so a redirected PC produces a new miss.
- if_re dropping mid-miss: the fill still completes, then the block returns to IDLE.
- c_we is asserted only in FILL and never overlaps c_re in the same cycle.
- m_req is deasserted in the cycle after m_rdy, releasing the port to the data side.

Decomposition:
- Shared package icache_pkg:
  - state encoding: IDLE=3'd0, COMPARE=1, REQ=2, MEM_WAIT=3, FILL=4, RETRY=5
  - LINE_W=64, TAG_W=11, INDEX_W=3, WORD_SEL_W=2
- One sub-module, icache_word_mux: combinational 64->16 word select on if_addr[1:0].
- FSM and latency counter stay in icache_ctrl.

Test Plan:
- Reset then fetch addr 16'h0008 on a cold cache -> stall high 8 cycles, m_addr=14'h0002, one c_we pulse with c_wr_data=memory line, instr = word 0 of that line, stall=0 on the 9th cycle.
- Fetch 16'h0009, 16'h000A, 16'h000B back-to-back after that fill -> stall=0 every cycle, instr = words 1, 2, 3, no m_req.
- Conflict: fetch 16'h0008 then 16'h0028 (same index 2, different tag) -> second fetch misses, refills index 2; a re-fetch of 16'h0008 misses again.
- Grant withheld 5 cycles on a miss -> block stays in REQ with m_req=1 and m_re=0; total stall = 8+5 = 13 cycles.
- rst_n pulsed low during MEM_WAIT -> all outputs return to reset values asynchronously, c_we never pulses; the next fetch restarts a clean miss.
- if_re deasserted during MEM_WAIT -> FILL still writes the line, FSM ends in IDLE with stall=0; a later fetch of the same address hits with zero stall.
